// File: rtl/uart_pkg.sv
// Shared constants for the UART receiver: baud encodings, 16x tick divisors at 18.432 MHz,
// receiver FSM states and the default oversampling ratio.
package uart_pkg;

  localparam logic [1:0] BAUD_9600   = 2'b00;
  localparam logic [1:0] BAUD_19200  = 2'b01;
  localparam logic [1:0] BAUD_38400  = 2'b10;
  localparam logic [1:0] BAUD_115200 = 2'b11;

  localparam int DIV_9600   = 120;
  localparam int DIV_19200  = 60;
  localparam int DIV_38400  = 30;
  localparam int DIV_115200 = 10;
  localparam int DIV_W      = 7;

  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  function automatic logic [DIV_W-1:0] baud_divisor(input logic [1:0] sel);
    logic [DIV_W-1:0] div;
    case (sel)
      BAUD_9600:   div = DIV_W'(DIV_9600);
      BAUD_19200:  div = DIV_W'(DIV_19200);
      BAUD_38400:  div = DIV_W'(DIV_38400);
      BAUD_115200: div = DIV_W'(DIV_115200);
      default:     div = DIV_W'(DIV_9600);
    endcase
    return div;
  endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick generator: one-clock tick every baud_divisor(baud_sel) clocks.
// A clear restarts the count so ticks line up with the detected start edge.
module uart_rx_tick_gen
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic       clear,
  output logic       tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_m1;

  assign div_m1 = baud_divisor(baud_sel) - DIV_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == div_m1) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + DIV_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver (8N1 by default). Define UART_RX_PARITY_EN to add a parity
// bit after the data bits, with sense chosen by PARITY_ODD; the port list is the same either way.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           baud_sel,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam int BC_W = 4;
  localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0] PH_END  = PH_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

  logic                 rx_p0, rxs, rxs_p2;
  rx_state_t            state;
  logic [1:0]           baud_lat;
  logic [PH_W-1:0]      phase;
  logic [BC_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shift_q;
  logic                 tick;
  logic                 start_edge;
`ifdef UART_RX_PARITY_EN
  logic                 parity_bad;
`endif

  // Stage p0/p1: two-flop synchronizer; rxs_p2 keeps the previous value for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0  <= 1'b1;
      rxs    <= 1'b1;
      rxs_p2 <= 1'b1;
    end else begin
      rx_p0  <= rx;
      rxs    <= rx_p0;
      rxs_p2 <= rxs;
    end
  end

  assign start_edge = (state == ST_IDLE) && rxs_p2 && !rxs;

  uart_rx_tick_gen u_tick_gen (
    .clk      (clk),
    .rst      (rst),
    .baud_sel (baud_lat),
    .clear    (start_edge),
    .tick     (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      baud_lat   <= BAUD_9600;
      phase      <= '0;
      bit_cnt    <= '0;
      shift_q    <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      rx_valid   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          baud_lat <= baud_sel;
          if (start_edge) begin
            state   <= ST_START;
            busy    <= 1'b1;
            phase   <= '0;
            bit_cnt <= '0;
          end
        end
        // Start bit is checked half a bit in; afterwards every sample lands mid-bit
        ST_START: begin
          if (tick) begin
            if (phase == PH_MID) begin
              phase <= '0;
              if (rxs) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end else begin
                state <= ST_DATA;
              end
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (phase == PH_END) begin
              phase   <= '0;
              shift_q <= {rxs, shift_q[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + BC_W'(1);
              if (bit_cnt == BC_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (tick) begin
            if (phase == PH_END) begin
              phase      <= '0;
              parity_bad <= rxs != ((^shift_q) ^ PARITY_ODD[0]);
              state      <= ST_STOP;
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
        end
`endif
        // Leaving at mid-stop lets the next start edge arrive with no idle gap
        ST_STOP: begin
          if (tick) begin
            if (phase == PH_END) begin
              phase <= '0;
              if (rxs) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err <= parity_bad;
`endif
                state    <= ST_IDLE;
                busy     <= 1'b0;
              end else begin
                frame_err <= 1'b1;
                state     <= ST_BREAK;
              end
            end else begin
              phase <= phase + PH_W'(1);
            end
          end
        end
        ST_BREAK: begin
          if (rxs) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: frames are built from random bytes, the expected
// outcome is queued at send time, and a monitor pops and compares on every output pulse.
module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] baud_sel = 2'b00;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, parity_err, busy;

  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .baud_sel   (baud_sel),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
    bit         perr;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         t_busy_fall = 0;
  logic       busy_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int bit_clks(input logic [1:0] sel);
    int baud[4] = '{9600, 19200, 38400, 115200};
    return 18432000 / baud[sel];
  endfunction

  task automatic drive(input logic v, input int clks);
    rx = v;
    repeat (clks) @(posedge clk);
  endtask

  // Odd parity: the parity bit makes the total count of ones odd
  task automatic send_frame(input logic [7:0] d, input logic [1:0] sel,
                            input bit stop_ok, input bit par_flip);
    int   bc;
    exp_t e;
    logic p;
    bc = bit_clks(sel);
    baud_sel = sel;
    if (stop_ok) begin
      e.is_ferr = 1'b0;
      e.data    = d;
      e.perr    = PAR_EN && par_flip;
      last_good = d;
    end else begin
      e.is_ferr = 1'b1;
      e.data    = last_good;
      e.perr    = 1'b0;
    end
    exp_q.push_back(e);
    drive(1'b0, bc);
    for (int i = 0; i < 8; i++) drive(d[i], bc);
    if (PAR_EN) begin
      p = ~(^d);
      if (par_flip) p = ~p;
      drive(p, bc);
    end
    drive(stop_ok, bc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    busy_d <= busy;
    if (busy_d && !busy) t_busy_fall = cyc;
  end

  // Monitor: every output pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && frame_err) check("valid_ferr_exclusive", 32'd1, 32'd0);
      if (rx_valid || frame_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, rx_valid, frame_err}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pulse_kind_ferr", {31'd0, frame_err}, {31'd0, e.is_ferr});
          check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
        end
      end else if (parity_err) begin
        check("stray_parity_err", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    int t_start;
    int limit;
    logic [7:0] d;
    logic [1:0] sel;
    bit stop_ok;
    bit flip;
    int gap;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("rst_outputs", {28'd0, rx_valid, frame_err, parity_err, busy}, 32'd0);
    @(posedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // 0xA5 at 9600; busy must fall within about 1 ms of the start edge
    t_start = cyc;
    send_frame(8'hA5, 2'b00, 1'b1, 1'b0);
    #1;
    limit = PAR_EN ? bit_clks(2'b00) * 11 : 18432;
    check("t1_busy_low", {31'd0, busy}, 32'd0);
    check("t1_busy_fall_window", {31'd0, (t_busy_fall > t_start) && (t_busy_fall - t_start <= limit)}, 32'd1);
    check("t1_drained", exp_q.size(), 32'd0);

    // Back-to-back frames at 115200 with no idle gap
    send_frame(8'h00, 2'b11, 1'b1, 1'b0);
    send_frame(8'hFF, 2'b11, 1'b1, 1'b0);
    drive(1'b1, 2 * bit_clks(2'b11));
    check("t2_drained", exp_q.size(), 32'd0);

    // Glitch shorter than half a bit at 19200 is a false start
    baud_sel = 2'b01;
    drive(1'b0, 40);
    #1;
    check("t3_busy_during_glitch", {31'd0, busy}, 32'd1);
    drive(1'b1, 700);
    #1;
    check("t3_busy_after_glitch", {31'd0, busy}, 32'd0);

    // Bad stop bit, then line held low: exactly one frame_err; then a clean frame
    send_frame(8'h55, 2'b11, 1'b0, 1'b0);
    drive(1'b0, 30 * bit_clks(2'b11));
    drive(1'b1, 2 * bit_clks(2'b11));
    send_frame(8'h81, 2'b11, 1'b1, 1'b0);
    drive(1'b1, 2 * bit_clks(2'b11));
    check("t4_drained", exp_q.size(), 32'd0);

    // Reset in the middle of data bit 4 of 0x3C
    baud_sel = 2'b11;
    d = 8'h3C;
    drive(1'b0, bit_clks(2'b11));
    for (int i = 0; i < 4; i++) drive(d[i], bit_clks(2'b11));
    drive(d[4], bit_clks(2'b11) / 2);
    rst = 1'b1;
    #1;
    check("t5_rst_rx_data", {24'd0, rx_data}, 32'd0);
    check("t5_rst_outputs", {28'd0, rx_valid, frame_err, parity_err, busy}, 32'd0);
    last_good = 8'h00;
    rx = 1'b1;
    repeat (3) @(posedge clk);
    rst = 1'b0;
    repeat (20) @(posedge clk);
    send_frame(8'h3C, 2'b11, 1'b1, 1'b0);
    drive(1'b1, 2 * bit_clks(2'b11));

    // baud_sel changes mid-frame; the frame still decodes at the old rate
    fork
      send_frame(8'h96, 2'b10, 1'b1, 1'b0);
      begin
        repeat (1500) @(posedge clk);
        baud_sel = 2'b11;
      end
    join
    drive(1'b1, 200);
    send_frame(8'h4B, 2'b11, 1'b1, 1'b0);
    drive(1'b1, 2 * bit_clks(2'b11));
    check("t5_drained", exp_q.size(), 32'd0);

    // Parity: correct then flipped parity bit on 0x07
    send_frame(8'h07, 2'b11, 1'b1, 1'b0);
    send_frame(8'h07, 2'b11, 1'b1, 1'b1);
    drive(1'b1, 2 * bit_clks(2'b11));

    // Randomized frames
    for (int n = 0; n < 10; n++) begin
      sel     = 2'($urandom_range(2, 3));
      d       = 8'($urandom);
      stop_ok = ($urandom_range(0, 5) != 0);
      flip    = 1'($urandom_range(0, 1));
      gap     = stop_ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
      send_frame(d, sel, stop_ok, flip);
      drive(1'b1, gap * bit_clks(sel));
    end
    drive(1'b1, 1000);
    #1;
    check("final_drained", exp_q.size(), 32'd0);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
